// File: rtl/clk_rst_pkg.sv
// Shared types for the clock/reset sequencer: FSM state encoding and
// lock-loss counter geometry.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  localparam int unsigned         LOSS_CNT_W   = 16;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous reset to 0.
// Brings an asynchronous level into the clk domain with two cycles of latency.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic lk_p0;
  (* ASYNC_REG = "TRUE" *) logic lk_p1;

  // Two back-to-back capture flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_p0 <= 1'b0;
      lk_p1 <= 1'b0;
    end else begin
      lk_p0 <= d;
      lk_p1 <= lk_p0;
    end
  end

  assign q = lk_p1;

endmodule

// File: rtl/clock_reset_sequencer.sv
// Clock/reset sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the per-domain resets one at a time in index order.
// Any lock loss after release has begun re-asserts every domain reset and
// is counted in a saturating 16-bit counter.
module clock_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS        = 4,
  parameter int unsigned PLL_RST_CYCLES     = 64,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RELEASE_GAP        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   all_ready,
  output logic [LOSS_CNT_W-1:0]  lock_loss_count,
  output logic [2:0]             state_dbg
);

  // One down-counter is shared by every timed state, so it is sized for the
  // longest interval.
  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > RELEASE_GAP) ? LOCK_STABLE_CYCLES : RELEASE_GAP;
  localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;
  localparam int unsigned IDX_W   = $clog2(NUM_DOMAINS) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LOAD = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             lk;

  // Saturating increment for the lock-loss counter.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (v == LOSS_CNT_MAX) ? v : v + 1'b1;
  endfunction

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // Sequencer FSM: state, shared counter, release index and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= PLL_RESET;
      cnt             <= PLL_RST_LOAD;
      idx             <= '0;
      pll_rst         <= 1'b1;
      domain_rst      <= '1;
      all_ready       <= 1'b0;
      lock_loss_count <= '0;
    end else if ((state == RELEASE || state == RUN) && !lk) begin
      // Lock lost after release began: pull every domain back into reset and
      // wait for relock without pulsing the PLL. This wins over any release
      // that would otherwise happen on this edge.
      state           <= WAIT_LOCK;
      cnt             <= TIMEOUT_LOAD;
      idx             <= '0;
      domain_rst      <= '1;
      all_ready       <= 1'b0;
      lock_loss_count <= sat_inc(lock_loss_count);
    end else begin
      case (state)
        PLL_RESET: begin
          if (cnt == '0) begin
            state   <= WAIT_LOCK;
            cnt     <= TIMEOUT_LOAD;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (lk) begin
            state <= STABILIZE;
            cnt   <= STABLE_LOAD;
          end else if (cnt == '0) begin
            state   <= PLL_RESET;
            cnt     <= PLL_RST_LOAD;
            pll_rst <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STABILIZE: begin
          if (!lk) begin
            // A dropout before release is only a failed qualification, not a loss.
            state <= WAIT_LOCK;
            cnt   <= TIMEOUT_LOAD;
          end else if (cnt == '0) begin
            domain_rst[0] <= 1'b0;
            if (NUM_DOMAINS == 1) begin
              state     <= RUN;
              all_ready <= 1'b1;
            end else begin
              state <= RELEASE;
              idx   <= IDX_W'(1);
              cnt   <= GAP_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RELEASE: begin
          if (cnt == '0) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (idx == IDX_W'(i)) domain_rst[i] <= 1'b0;
            end
            if (idx == LAST_IDX) begin
              state     <= RUN;
              all_ready <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
            cnt <= GAP_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RUN: begin
          state <= RUN;
        end

        default: begin
          state      <= PLL_RESET;
          cnt        <= PLL_RST_LOAD;
          idx        <= '0;
          pll_rst    <= 1'b1;
          domain_rst <= '1;
          all_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
